// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with a Start/Busy/Done handshake.
// Shifts run bit-serially, multiply is shift-add over W cycles.
module alu_mc #(
  parameter int W   = 8,
  parameter int Ops = 4
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic           Start,
  input  logic [Ops-1:0] OP,
  input  logic [W-1:0]   InputA,
  input  logic [W-1:0]   InputB,
  input  logic           SetFlags,
  output logic [W-1:0]   Out,
  output logic           Done,
  output logic           Busy,
  output logic           Zero,
  output logic           Carry
);

  localparam int CW = $clog2(W + 1);

  localparam logic [Ops-1:0] OP_ADD = Ops'(0);
  localparam logic [Ops-1:0] OP_SUB = Ops'(1);
  localparam logic [Ops-1:0] OP_XOR = Ops'(2);
  localparam logic [Ops-1:0] OP_ORR = Ops'(3);
  localparam logic [Ops-1:0] OP_RXR = Ops'(4);
  localparam logic [Ops-1:0] OP_LSH = Ops'(5);
  localparam logic [Ops-1:0] OP_RSH = Ops'(6);
  localparam logic [Ops-1:0] OP_MUL = Ops'(7);
  localparam logic [Ops-1:0] OP_ADC = Ops'(8);

  localparam logic [W:0]    WMAX = (W + 1)'(W);
  localparam logic [CW-1:0] CMAX = CW'(W);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    MUL
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]   out_q, out_d;
  logic           done_q, done_d;
  logic           zero_q, zero_d;
  logic           carry_q, carry_d;
  logic           setf_q, setf_d;
  logic           dir_q, dir_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   sh_q, sh_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] mcd_q, mcd_d;
  logic [W-1:0]   mpl_q, mpl_d;

  logic [CW-1:0]  n;
  logic [W-1:0]   bop;
  logic           cin;
  logic [W:0]     sum;
  logic [W-1:0]   sh_n;
  logic           sh_bit;
  logic [2*W-1:0] acc_n;
  logic [W-1:0]   res;
  logic           cres;
  logic           iter;

  // shift count clamps at W; adder operand shaping for SUB/ADC
  assign n = ({1'b0, InputB} > WMAX) ? CMAX : InputB[CW-1:0];
  assign bop = (OP == OP_SUB) ? ~InputB : InputB;
  assign cin = (OP == OP_SUB) | ((OP == OP_ADC) & carry_q);
  assign sum = {1'b0, InputA} + {1'b0, bop} + {{W{1'b0}}, cin};

  // one serial step of the shifter and of the multiplier
  assign sh_n = dir_q ? {sh_q[W-2:0], 1'b0} : {1'b0, sh_q[W-1:1]};
  assign sh_bit = dir_q ? sh_q[W-1] : sh_q[0];
  assign acc_n = mpl_q[0] ? (acc_q + mcd_q) : acc_q;

  assign Out   = out_q;
  assign Done  = done_q;
  assign Busy  = (state_q != IDLE);
  assign Zero  = zero_q;
  assign Carry = carry_q;

  // state and datapath registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      setf_q  <= 1'b0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      sh_q    <= '0;
      acc_q   <= '0;
      mcd_q   <= '0;
      mpl_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      done_q  <= done_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      setf_q  <= setf_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      mcd_q   <= mcd_d;
      mpl_q   <= mpl_d;
    end
  end

  // next state, result and flag update
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    done_d  = 1'b0;
    zero_d  = zero_q;
    carry_d = carry_q;
    setf_d  = setf_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    mcd_d   = mcd_q;
    mpl_d   = mpl_q;
    res     = '0;
    cres    = carry_q;
    iter    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          setf_d = SetFlags;
          case (OP)
            OP_ADD, OP_SUB, OP_ADC: begin
              res  = sum[W-1:0];
              cres = sum[W];
            end
            OP_XOR: res = InputA ^ InputB;
            OP_ORR: res = InputA | InputB;
            OP_RXR: res = {{(W-1){1'b0}}, ^InputA};
            OP_LSH, OP_RSH: begin
              if (n == '0) begin
                res = InputA;
              end else begin
                iter    = 1'b1;
                state_d = SHIFT;
                sh_d    = InputA;
                cnt_d   = n;
                dir_d   = (OP == OP_LSH);
              end
            end
            OP_MUL: begin
              iter    = 1'b1;
              state_d = MUL;
              acc_d   = '0;
              mcd_d   = {{W{1'b0}}, InputA};
              mpl_d   = InputB;
              cnt_d   = CMAX;
            end
            default: res = '0;
          endcase
          if (!iter) begin
            out_d  = res;
            done_d = 1'b1;
            if (SetFlags) begin
              zero_d  = (res == '0);
              carry_d = cres;
            end
          end
        end
      end
      SHIFT: begin
        sh_d  = sh_n;
        cnt_d = cnt_q - ONE;
        if (cnt_q == ONE) begin
          state_d = IDLE;
          out_d   = sh_n;
          done_d  = 1'b1;
          if (setf_q) begin
            zero_d  = (sh_n == '0);
            carry_d = sh_bit;
          end
        end
      end
      MUL: begin
        acc_d = acc_n;
        mcd_d = {mcd_q[2*W-2:0], 1'b0};
        mpl_d = {1'b0, mpl_q[W-1:1]};
        cnt_d = cnt_q - ONE;
        if (cnt_q == ONE) begin
          state_d = IDLE;
          out_d   = acc_n[W-1:0];
          done_d  = 1'b1;
          if (setf_q) begin
            zero_d  = (acc_n[W-1:0] == '0);
            carry_d = |acc_n[2*W-1:W];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed vectors for alu_mc.
// Expected values are hand-computed.
module tb_alu_mc;

  logic       Clk;
  logic       Reset_n;
  logic       Start;
  logic [3:0] OP;
  logic [7:0] InputA;
  logic [7:0] InputB;
  logic       SetFlags;
  logic [7:0] Out;
  logic       Done;
  logic       Busy;
  logic       Zero;
  logic       Carry;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] last_out = '0;

  alu_mc #(.W(8), .Ops(4)) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .Start(Start),
    .OP(OP),
    .InputA(InputA),
    .InputB(InputB),
    .SetFlags(SetFlags),
    .Out(Out),
    .Done(Done),
    .Busy(Busy),
    .Zero(Zero),
    .Carry(Carry)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run(input string tag, input logic [3:0] op,
                     input logic [7:0] a, input logic [7:0] b,
                     input logic sf, input int lat_e,
                     input logic [7:0] out_e,
                     input logic z_e, input logic c_e);
    int lat;
    int bc;
    bit held;
    @(negedge Clk);
    OP = op;
    InputA = a;
    InputB = b;
    SetFlags = sf;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    InputA = ~a;
    InputB = ~b;
    SetFlags = ~sf;
    lat = 1;
    bc = 0;
    held = 1'b1;
    while (!Done && lat < 40) begin
      if (Busy) bc++;
      if (Out !== last_out) held = 1'b0;
      @(posedge Clk);
      #1;
      lat++;
    end
    check({tag, "_done"}, Done, 1);
    check({tag, "_lat"}, lat, lat_e);
    check({tag, "_busycyc"}, bc, lat_e - 1);
    check({tag, "_held"}, held, 1);
    check({tag, "_busy"}, Busy, 0);
    check({tag, "_out"}, Out, out_e);
    check({tag, "_zero"}, Zero, z_e);
    check({tag, "_carry"}, Carry, c_e);
    last_out = out_e;
  endtask

  initial begin
    int dones;
    int dl;
    logic [7:0] o;
    logic z;
    logic c;
    Reset_n = 1'b0;
    Start = 1'b0;
    OP = '0;
    InputA = '0;
    InputB = '0;
    SetFlags = 1'b0;
    #12;
    check("rst_out", Out, 0);
    check("rst_done", Done, 0);
    check("rst_busy", Busy, 0);
    check("rst_zero", Zero, 0);
    check("rst_carry", Carry, 0);
    @(negedge Clk);
    Reset_n = 1'b1;

    run("add", 4'd0, 8'd200, 8'd100, 1'b1, 1, 8'd44, 1'b0, 1'b1);
    run("rxr", 4'd4, 8'h07, 8'h00, 1'b1, 1, 8'd1, 1'b0, 1'b1);

    @(negedge Clk);
    OP = 4'd1;
    InputA = 8'd5;
    InputB = 8'd5;
    SetFlags = 1'b1;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    check("sub_done", Done, 1);
    check("sub_out", Out, 0);
    check("sub_zero", Zero, 1);
    check("sub_carry", Carry, 1);
    OP = 4'd8;
    InputA = 8'd1;
    InputB = 8'd1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    check("adc_done", Done, 1);
    check("adc_out", Out, 3);
    check("adc_zero", Zero, 0);
    check("adc_carry", Carry, 0);
    @(posedge Clk);
    #1;
    check("adc_done_drop", Done, 0);
    last_out = 8'd3;

    run("lsh", 4'd5, 8'h81, 8'd3, 1'b1, 4, 8'h08, 1'b0, 1'b0);
    run("rsh", 4'd6, 8'h81, 8'd9, 1'b1, 9, 8'h00, 1'b1, 1'b1);
    run("mul1", 4'd7, 8'd13, 8'd20, 1'b1, 9, 8'h04, 1'b0, 1'b1);
    run("xor", 4'd2, 8'h3c, 8'h3c, 1'b0, 1, 8'h00, 1'b0, 1'b1);

    @(negedge Clk);
    OP = 4'd7;
    InputA = 8'd12;
    InputB = 8'd10;
    SetFlags = 1'b1;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    dones = 0;
    dl = 0;
    o = '0;
    z = 1'b0;
    c = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      if (i == 3) begin
        OP = 4'd2;
        InputA = 8'hff;
        InputB = 8'hff;
        Start = 1'b1;
      end
      if (i == 4) Start = 1'b0;
      if (Done) begin
        dones++;
        if (dl == 0) begin
          dl = i;
          o = Out;
          z = Zero;
          c = Carry;
        end
      end
      @(posedge Clk);
      #1;
    end
    check("mul2_dones", dones, 1);
    check("mul2_lat", dl, 9);
    check("mul2_out", o, 120);
    check("mul2_zero", z, 0);
    check("mul2_carry", c, 0);

    @(negedge Clk);
    OP = 4'd7;
    InputA = 8'd3;
    InputB = 8'd3;
    SetFlags = 1'b1;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    check("mul3_busy", Busy, 1);
    repeat (3) @(posedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    check("arst_out", Out, 0);
    check("arst_busy", Busy, 0);
    check("arst_done", Done, 0);
    check("arst_zero", Zero, 0);
    check("arst_carry", Carry, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge Clk);
      #1;
      if (Done) dones++;
    end
    check("arst_nodone", dones, 0);
    last_out = '0;

    run("rsh0", 4'd6, 8'h55, 8'd0, 1'b1, 1, 8'h55, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
